// File: rtl/ballot_pkg.sv
// rtl/ballot_pkg.sv - shared types, defaults and helpers for the ballot console
package ballot_pkg;

    typedef enum logic [2:0] {
        ST_LOCKED,
        ST_ARMED,
        ST_SELECTED,
        ST_SEND_VOTE,
        ST_SEND_CONFIRM,
        ST_VVPAT
    } state_e;

    typedef enum logic [1:0] {
        CAND_NONE = 2'b00,
        CAND_A    = 2'b01,
        CAND_B    = 2'b10,
        CAND_C    = 2'b11
    } cand_e;

    localparam int TIMEOUT_CYCLES_DEF = 1000;
    localparam int VVPAT_CYCLES_DEF   = 16;
    localparam int TOTAL_W_DEF        = 10;

    // Candidate edge vector is {C, B, A}
    function automatic logic single_hot(input logic [2:0] v);
        return (v == 3'b001) || (v == 3'b010) || (v == 3'b100);
    endfunction

    function automatic cand_e onehot_to_cand(input logic [2:0] v);
        cand_e c;
        case (v)
            3'b001:  c = CAND_A;
            3'b010:  c = CAND_B;
            3'b100:  c = CAND_C;
            default: c = CAND_NONE;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/btn_edge_det.sv
// rtl/btn_edge_det.sv - registered rising-edge detector for a vector of debounced levels
module btn_edge_det #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [W-1:0] btn_i,
    output logic [W-1:0] rise_o
);

    logic [W-1:0] prev_q;
    logic [W-1:0] rise_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            prev_q <= '0;
            rise_q <= '0;
        end else begin
            prev_q <= btn_i;
            rise_q <= btn_i & ~prev_q;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/ballot_unit.sv
// rtl/ballot_unit.sv - voter console FSM driving the vote counter; VVPAT_EN adds the VVPAT display state
module ballot_unit
    import ballot_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int VVPAT_CYCLES   = VVPAT_CYCLES_DEF,
    parameter int TOTAL_W        = TOTAL_W_DEF
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               ballot_issue,
    input  logic               btn_A,
    input  logic               btn_B,
    input  logic               btn_C,
    input  logic               btn_confirm,
    output logic               enable_vote,
    output logic               vote_A,
    output logic               vote_B,
    output logic               vote_C,
    output logic               confirm_vote,
    output logic               ready,
    output logic [1:0]         sel,
    output logic               timeout_pulse,
    output logic [TOTAL_W-1:0] ballots_cast,
    output logic               vvpat_show
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > VVPAT_CYCLES) ? TIMEOUT_CYCLES : VVPAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic [4:0] rise;
    logic       issue_e, conf_e, one_cand;
    logic [2:0] cand_e_v;

    btn_edge_det #(.W(5)) u_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_i   ({btn_confirm, btn_C, btn_B, btn_A, ballot_issue}),
        .rise_o  (rise)
    );

    assign issue_e  = rise[0];
    assign cand_e_v = rise[3:1];
    assign conf_e   = rise[4];
    assign one_cand = single_hot(cand_e_v);

    state_e             state_q, state_d;
    cand_e              sel_q, sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TOTAL_W-1:0] total_q, total_d;
    logic [2:0]         vote_q, vote_d;
    logic               enable_q, enable_d, confirm_q, confirm_d;
    logic               ready_q, ready_d, tmo_q, tmo_d, vvpat_q, vvpat_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= ST_LOCKED;
            sel_q     <= CAND_NONE;
            cnt_q     <= '0;
            total_q   <= '0;
            vote_q    <= '0;
            enable_q  <= 1'b0;
            confirm_q <= 1'b0;
            ready_q   <= 1'b0;
            tmo_q     <= 1'b0;
            vvpat_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            total_q   <= total_d;
            vote_q    <= vote_d;
            enable_q  <= enable_d;
            confirm_q <= confirm_d;
            ready_q   <= ready_d;
            tmo_q     <= tmo_d;
            vvpat_q   <= vvpat_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        tmo_d   = 1'b0;
        case (state_q)
            ST_LOCKED: begin
                sel_d = CAND_NONE;
                cnt_d = '0;
                if (issue_e) state_d = ST_ARMED;
            end
            ST_ARMED, ST_SELECTED: begin
                // Confirm outranks any coincident candidate edge
                if (state_q == ST_SELECTED && conf_e) begin
                    state_d = ST_SEND_VOTE;
                    cnt_d   = '0;
                end else if (one_cand) begin
                    state_d = ST_SELECTED;
                    sel_d   = onehot_to_cand(cand_e_v);
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    sel_d   = CAND_NONE;
                    cnt_d   = '0;
                    tmo_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_SEND_VOTE: state_d = ST_SEND_CONFIRM;
            ST_SEND_CONFIRM: begin
                cnt_d = '0;
`ifdef VVPAT_EN
                state_d = ST_VVPAT;
`else
                state_d = ST_LOCKED;
                sel_d   = CAND_NONE;
`endif
            end
            ST_VVPAT: begin
`ifdef VVPAT_EN
                if (cnt_q == CNT_W'(VVPAT_CYCLES - 1)) begin
                    state_d = ST_LOCKED;
                    sel_d   = CAND_NONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
`else
                state_d = ST_LOCKED;
                sel_d   = CAND_NONE;
`endif
            end
            default: begin
                state_d = ST_LOCKED;
                sel_d   = CAND_NONE;
                cnt_d   = '0;
            end
        endcase

        enable_d  = (state_d == ST_SEND_VOTE) || (state_d == ST_SEND_CONFIRM);
        confirm_d = (state_d == ST_SEND_CONFIRM);
        ready_d   = (state_d == ST_ARMED) || (state_d == ST_SELECTED);
        vote_d    = '0;
        if (state_d == ST_SEND_VOTE)
            vote_d = {sel_d == CAND_C, sel_d == CAND_B, sel_d == CAND_A};
        total_d = total_q;
        if (state_d == ST_SEND_CONFIRM && total_q != {TOTAL_W{1'b1}})
            total_d = total_q + TOTAL_W'(1);
`ifdef VVPAT_EN
        vvpat_d = (state_d == ST_VVPAT);
`else
        vvpat_d = 1'b0;
`endif
    end

    assign enable_vote   = enable_q;
    assign vote_A        = vote_q[0];
    assign vote_B        = vote_q[1];
    assign vote_C        = vote_q[2];
    assign confirm_vote  = confirm_q;
    assign ready         = ready_q;
    assign sel           = sel_q;
    assign timeout_pulse = tmo_q;
    assign ballots_cast  = total_q;
    assign vvpat_show    = vvpat_q;

endmodule
